// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display path.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied only at the output register.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam int DD_STEPS = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MINUTE   = 2'd2;
  localparam logic [1:0] DIG_BLANK    = 2'd3;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Bus between the stopwatch core (master) and the display driver (slave).
interface stopwatch_display_if;
  logic [1:0] minute;
  logic [5:0] second;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  modport master (output minute, second, input seg, dp, an, busy);
  modport slave  (input minute, second, output seg, dp, an, busy);
endinterface

// File: rtl/stopwatch_display_bcd.sv
// Iterative 6-bit binary to two-digit BCD converter (double-dabble, one step per clock).
module bin6_to_bcd
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [5:0] i_bin,
  output logic       o_done,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [13:0] r_sr;
  logic [2:0]  r_step;
  logic        r_active;
  logic [13:0] w_adj;

  always_comb begin
    w_adj = r_sr;
    if (r_sr[13:10] >= 4'd5) w_adj[13:10] = r_sr[13:10] + 4'd3;
    if (r_sr[9:6]   >= 4'd5) w_adj[9:6]   = r_sr[9:6]   + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr     <= '0;
      r_step   <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_sr     <= {8'd0, i_bin};
      r_step   <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_sr   <= {w_adj[12:0], 1'b0};
      r_step <= r_step + 3'd1;
      if (r_step == 3'(DD_STEPS - 1)) r_active <= 1'b0;
    end
  end

  // done flags the cycle whose edge performs the final step
  assign o_done = r_active && (r_step == 3'(DD_STEPS - 1));
  assign o_tens = r_sr[13:10];
  assign o_ones = r_sr[9:6];

endmodule

// File: rtl/stopwatch_display.sv
// Change-detecting BCD conversion and 4-digit multiplexed " M.SS" display scan.
//   state     | meaning
//   ST_IDLE   | compare input against last captured value
//   ST_CONV   | double-dabble running
//   ST_COMMIT | load digit registers from converter result
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input logic                clk,
  input logic                reset,
  stopwatch_display_if.slave bus
);

  localparam int   CW  = $clog2(SCAN_DIV);
  localparam logic INV = (ACTIVE_LOW != 0);

  conv_state_t r_state, w_next;
  logic        w_start, w_commit, w_done;
  logic [3:0]  w_tens, w_ones;
  logic [7:0]  r_last_val;
  logic [1:0]  r_d2;
  logic [3:0]  r_d1, r_d0;
  logic        r_err;
  logic [CW-1:0] r_scan_cnt;
  logic [1:0]  r_scan_idx;
  logic [6:0]  w_seg, r_seg;
  logic        w_dp, r_dp;
  logic [3:0]  w_an, r_an;

  bin6_to_bcd u_bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_bin   (bus.second),
    .o_done  (w_done),
    .o_tens  (w_tens),
    .o_ones  (w_ones)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ({bus.minute, bus.second} != r_last_val) begin
          w_start = 1'b1;
          w_next  = ST_CONV;
        end
      end
      ST_CONV:   if (w_done) w_next = ST_COMMIT;
      ST_COMMIT: begin
        w_commit = 1'b1;
        w_next   = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_val <= '0;
      r_d2       <= '0;
      r_d1       <= '0;
      r_d0       <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_start) r_last_val <= {bus.minute, bus.second};
      if (w_commit) begin
        r_d2  <= r_last_val[7:6];
        r_d1  <= w_tens;
        r_d0  <= w_ones;
        r_err <= (r_last_val[5:0] > 6'd59);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= DIG_SEC_ONES;
    end else if (r_scan_cnt == CW'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + CW'(1);
    end
  end

  always_comb begin
    w_seg = SEG_BLANK;
    w_dp  = 1'b0;
    w_an  = 4'b1000;
    case (r_scan_idx)
      DIG_SEC_ONES: begin
        w_seg = r_err ? SEG_DASH : seg_of(r_d0);
        w_an  = 4'b0001;
      end
      DIG_SEC_TENS: begin
        w_seg = r_err ? SEG_DASH : seg_of(r_d1);
        w_an  = 4'b0010;
      end
      DIG_MINUTE: begin
        w_seg = seg_of({2'b00, r_d2});
        w_dp  = 1'b1;
        w_an  = 4'b0100;
      end
      default: ;
    endcase
  end

  // polarity is applied here only, so internal logic stays active-high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_0 ^ {7{INV}};
      r_dp  <= INV;
      r_an  <= 4'b0001 ^ {4{INV}};
    end else begin
      r_seg <= w_seg ^ {7{INV}};
      r_dp  <= w_dp ^ INV;
      r_an  <= w_an ^ {4{INV}};
    end
  end

  assign bus.seg  = r_seg;
  assign bus.dp   = r_dp;
  assign bus.an   = r_an;
  assign bus.busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_stopwatch_display.sv
// Randomized self-checking bench: active-low and active-high instances against a behavioural display model.
module tb_stopwatch_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] r_min;
  logic [5:0] r_sec;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_display_if if_al ();
  stopwatch_display_if if_ah ();

  assign if_al.minute = r_min;
  assign if_al.second = r_sec;
  assign if_ah.minute = r_min;
  assign if_ah.second = r_sec;

  stopwatch_display #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .reset(reset), .bus(if_al.slave));
  stopwatch_display #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)) u_dut_ah (
    .clk(clk), .reset(reset), .bus(if_ah.slave));

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [10];
  int         k;
  int         rem;
  logic [7:0] last;
  logic [1:0] dmin;
  logic [5:0] dsec;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;
  logic       e_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, shown %0d:%0d)", tag, obs, exp, $time, dmin, dsec);
    end
  endtask

  task automatic set_exp(input int idx);
    e_an = 4'(1 << idx);
    e_dp = (idx == 2);
    case (idx)
      0:       e_seg = (dsec > 59) ? 7'h40 : seg_tbl[dsec % 10];
      1:       e_seg = (dsec > 59) ? 7'h40 : seg_tbl[dsec / 10];
      2:       e_seg = seg_tbl[dmin];
      default: e_seg = 7'h00;
    endcase
  endtask

  task automatic model_reset();
    k = 0; rem = 0; last = '0; dmin = '0; dsec = '0;
    set_exp(0);
    e_busy = 1'b0;
  endtask

  // one clock edge: output shows digits as they stood before this edge
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      k++;
      set_exp(((k - 1) / SCAN_DIV) % 4);
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          dmin = last[7:6];
          dsec = last[5:0];
        end
      end else if ({r_min, r_sec} != last) begin
        last = {r_min, r_sec};
        rem  = 7;
      end
      e_busy = (rem > 0);
    end
  endtask

  task automatic compare_all(input string pfx);
    logic [6:0] inv_seg;
    logic [3:0] inv_an;
    logic       inv_dp;
    inv_seg = ~e_seg;
    inv_an  = ~e_an;
    inv_dp  = ~e_dp;
    check({pfx, "_al_seg"},  if_al.seg,  inv_seg);
    check({pfx, "_al_an"},   if_al.an,   inv_an);
    check({pfx, "_al_dp"},   if_al.dp,   inv_dp);
    check({pfx, "_al_busy"}, if_al.busy, e_busy);
    check({pfx, "_ah_seg"},  if_ah.seg,  e_seg);
    check({pfx, "_ah_an"},   if_ah.an,   e_an);
    check({pfx, "_ah_dp"},   if_ah.dp,   e_dp);
    check({pfx, "_ah_busy"}, if_ah.busy, e_busy);
  endtask

  task automatic cycles(input int n, input string pfx);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_edge();
      compare_all(pfx);
    end
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("rst_async");
  endtask

  initial begin
    seg_tbl[0] = 7'h3F; seg_tbl[1] = 7'h06; seg_tbl[2] = 7'h5B; seg_tbl[3] = 7'h4F;
    seg_tbl[4] = 7'h66; seg_tbl[5] = 7'h6D; seg_tbl[6] = 7'h7D; seg_tbl[7] = 7'h07;
    seg_tbl[8] = 7'h7F; seg_tbl[9] = 7'h6F;
    r_min = 2'd0;
    r_sec = 6'd0;
    reset = 1'b0;
    #2;
    assert_reset();
    cycles(3, "rst_hold");
    reset = 1'b0;
    cycles(2, "rst_rel");

    r_min = 2'd1; r_sec = 6'd7;
    cycles(40, "m1s07");

    r_min = 2'd3; r_sec = 6'd60;
    cycles(40, "err60");
    r_sec = 6'd0;
    cycles(40, "clr300");

    r_min = 2'd0; r_sec = 6'd58;
    cycles(1, "cap58");
    r_sec = 6'd59;
    cycles(30, "s59");

    r_min = 2'd3; r_sec = 6'd59;
    cycles(20, "m3s59");
    r_min = 2'd0; r_sec = 6'd0;
    cycles(20, "wrap");

    r_min = 2'd2; r_sec = 6'd45;
    cycles(4, "pre_rst");
    assert_reset();
    cycles(2, "rst_mid");
    reset = 1'b0;
    cycles(30, "m2s45");

    for (int it = 0; it < 200; it++) begin
      r_min = 2'($urandom_range(0, 3));
      r_sec = 6'($urandom_range(0, 63));
      cycles($urandom_range(1, 12), "rand");
    end
    cycles(40, "settle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
